// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: reads DATA_W-bit words from a synchronous FIFO (one-cycle read latency) and
// packs PACK of them into one DATA_W*PACK-bit output word on a valid/ready stream.
//   clk, rst       : single clock, synchronous active-high reset
//   fifo_empty     : upstream FIFO empty flag
//   fifo_rd_en     : read request to upstream FIFO
//   fifo_dout      : FIFO read data, valid the cycle after fifo_rd_en
//   flush          : single-cycle request to emit a partially filled word
//   m_valid/m_ready: output handshake
//   m_data         : packed word, slot 0 in the least significant DATA_W bits
//   m_keep         : per-slot valid mask
//   busy           : assembly non-empty, read in flight, or output word held
module fifo_rd_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PACK   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_dout,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W*PACK-1:0]   m_data,
  output logic [PACK-1:0]          m_keep,
  output logic                     busy
);

  localparam int unsigned    CntW    = $clog2(PACK) + 1;
  localparam logic [CntW-1:0] PackCnt = CntW'(PACK);

  typedef enum logic [0:0] {StFill, StFlush} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          byte_cnt_q, byte_cnt_d;
  logic                     rd_pending_q, rd_pending_d;
  logic [DATA_W*PACK-1:0]   asm_q, asm_d;
  logic [DATA_W*PACK-1:0]   m_data_q, m_data_d;
  logic [PACK-1:0]          m_keep_q, m_keep_d;
  logic                     m_valid_q, m_valid_d;

  logic [CntW-1:0]          pend_ext;
  logic [CntW-1:0]          cnt_next;   // slot count including the word landing this cycle
  logic [DATA_W*PACK-1:0]   asm_next;   // assembly including the word landing this cycle
  logic [PACK-1:0]          keep_mask;
  logic                     out_free;
  logic                     load;

  assign pend_ext = {{(CntW-1){1'b0}}, rd_pending_q};
  assign out_free = !m_valid_q || m_ready;

  // A read is only issued if a free slot is guaranteed for its data, so nothing is ever dropped.
  assign fifo_rd_en = !rst && !fifo_empty && (state_q == StFill) &&
                      ((byte_cnt_q + pend_ext) < PackCnt);

  always_comb begin
    asm_next = asm_q;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (rd_pending_q && (byte_cnt_q == CntW'(i))) begin
        asm_next[i*DATA_W +: DATA_W] = fifo_dout;
      end
    end
    cnt_next = byte_cnt_q + pend_ext;
    for (int unsigned i = 0; i < PACK; i++) begin
      keep_mask[i] = (CntW'(i) < cnt_next);
    end
  end

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_next;
    byte_cnt_d   = cnt_next;
    rd_pending_d = fifo_rd_en;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q && !m_ready;
    load         = 1'b0;

    unique case (state_q)
      StFill: begin
        // Loading as the last slot lands keeps the read stream going at PACK words per
        // PACK+1 cycles. A flush coinciding with a full load has nothing left to flush.
        if ((cnt_next == PackCnt) && out_free) begin
          load = 1'b1;
        end else if (flush && ((byte_cnt_q != '0) || rd_pending_q)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        // No reads are issued here, so any pending word lands in asm_next this cycle.
        if (out_free) begin
          load    = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    if (load) begin
      m_data_d   = asm_next;
      m_keep_d   = keep_mask;
      m_valid_d  = 1'b1;
      asm_d      = '0;  // keeps unused slots of the next partial word zero
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      byte_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      asm_q        <= '0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_pending_q <= rd_pending_d;
      asm_q        <= asm_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign busy    = (byte_cnt_q != '0) || rd_pending_q || m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DATA_W=8, PACK=4) with a behavioural FIFO and a
// byte-list packing model.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PK = 4;

  logic clk = 1'b0;
  logic rst, fifo_empty, fifo_rd_en, flush, m_valid, m_ready, busy;
  logic [DW-1:0]    fifo_dout;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0]    m_keep;

  fifo_rd_packer #(.DATA_W(DW), .PACK(PK)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Upstream FIFO model: task side writes, clocked side reads.
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int rd_empty_viol = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (wr_ptr == rd_ptr) rd_empty_viol <= rd_empty_viol + 1;
      else begin
        fifo_dout <= fifo_mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Output monitor: accepted beats and stability while stalled.
  logic [31:0] beat_data_q [$];
  logic [3:0]  beat_keep_q [$];
  logic        stalled_q = 1'b0;
  logic [31:0] st_data;
  logic [3:0]  st_keep;
  int          stall_viol = 0;

  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) begin
      beat_data_q.push_back(m_data);
      beat_keep_q.push_back(m_keep);
    end
    if (!rst && stalled_q && (!m_valid || m_data !== st_data || m_keep !== st_keep))
      stall_viol <= stall_viol + 1;
    stalled_q <= !rst && m_valid && !m_ready;
    st_data   <= m_data;
    st_keep   <= m_keep;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 1024] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int t = 0;
    while (beat_data_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    ok = (beat_data_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    n_total++;
    if ({fifo_rd_en, m_valid, busy} !== 3'b000)
      $display("FAIL reset_ctrl got rd_en/valid/busy=%b want 000", {fifo_rd_en, m_valid, busy});
    else n_pass++;
    n_total++;
    if (m_data !== 32'h0 || m_keep !== 4'h0)
      $display("FAIL reset_data got data=%h keep=%b want 0/0", m_data, m_keep);
    else n_pass++;
  endtask

  task automatic test_basic();
    int base_b, base_rd;
    bit ok;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick();
    n_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL rd_en_in_reset got %b want 0", fifo_rd_en);
    else n_pass++;
    base_b = beat_data_q.size();
    base_rd = rd_cnt;
    rst = 1'b0; m_ready = 1'b1;
    wait_beats(base_b + 1, 50, ok);
    repeat (8) tick();
    n_total++;
    if (!ok || beat_data_q.size() != base_b + 1)
      $display("FAIL basic_beats got %0d want 1", beat_data_q.size() - base_b);
    else n_pass++;
    if (ok) begin
      n_total++;
      if (beat_data_q[base_b] !== 32'h44332211 || beat_keep_q[base_b] !== 4'b1111)
        $display("FAIL basic_data got %h/%b want 44332211/1111",
                 beat_data_q[base_b], beat_keep_q[base_b]);
      else n_pass++;
    end
    n_total++;
    if (rd_cnt - base_rd != 4) $display("FAIL basic_rd_cycles got %0d want 4", rd_cnt - base_rd);
    else n_pass++;
  endtask

  task automatic test_flush_partial();
    int base_b;
    bit ok;
    m_ready = 1'b1;
    base_b = beat_data_q.size();
    push(8'hA1); push(8'hB2); push(8'hC3);
    repeat (8) tick();
    n_total++;
    if (m_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL partial_hold got valid/busy=%b%b want 01", m_valid, busy);
    else n_pass++;
    flush = 1'b1; tick(); flush = 1'b0;
    wait_beats(base_b + 1, 20, ok);
    tick(); tick();
    n_total++;
    if (!ok || beat_data_q[base_b] !== 32'h00C3B2A1 || beat_keep_q[base_b] !== 4'b0111)
      $display("FAIL partial_data got %h/%b want 00c3b2a1/0111",
               ok ? beat_data_q[base_b] : 32'hx, ok ? beat_keep_q[base_b] : 4'hx);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL partial_busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int base_b, base_rd;
    bit ok;
    m_ready = 1'b0;
    base_b = beat_data_q.size();
    base_rd = rd_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (10) tick();
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'b1111)
      $display("FAIL stall_out got %b/%h/%b want 1/04030201/1111", m_valid, m_data, m_keep);
    else n_pass++;
    m_ready = 1'b1;
    wait_beats(base_b + 2, 30, ok);
    repeat (6) tick();
    n_total++;
    if (!ok || beat_data_q.size() != base_b + 2)
      $display("FAIL stall_beats got %0d want 2", beat_data_q.size() - base_b);
    else n_pass++;
    if (ok) begin
      n_total++;
      if (beat_data_q[base_b] !== 32'h04030201 || beat_data_q[base_b+1] !== 32'h08070605)
        $display("FAIL stall_data got %h,%h want 04030201,08070605",
                 beat_data_q[base_b], beat_data_q[base_b+1]);
      else n_pass++;
    end
    n_total++;
    if (rd_cnt - base_rd != 8) $display("FAIL stall_reads got %0d want 8", rd_cnt - base_rd);
    else n_pass++;
  endtask

  task automatic test_flush_on_last_read();
    int base_b;
    bit ok;
    m_ready = 1'b1;
    base_b = beat_data_q.size();
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    tick(); tick(); tick();
    n_total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL fourth_read_rd_en got %b want 1", fifo_rd_en);
    else n_pass++;
    flush = 1'b1; tick(); flush = 1'b0;
    wait_beats(base_b + 1, 20, ok);
    repeat (10) tick();
    n_total++;
    if (!ok || beat_data_q.size() != base_b + 1 || beat_data_q[base_b] !== 32'hC4C3C2C1 ||
        beat_keep_q[base_b] !== 4'b1111)
      $display("FAIL flush_last_read got %0d beats first=%h/%b want 1 beat c4c3c2c1/1111",
               beat_data_q.size() - base_b, ok ? beat_data_q[base_b] : 32'hx,
               ok ? beat_keep_q[base_b] : 4'hx);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int base_b;
    bit ok;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
    repeat (15) tick();
    n_total++;
    if (m_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL pre_reset got valid/busy=%b%b want 11", m_valid, busy);
    else n_pass++;
    rst = 1'b1; tick();
    n_total++;
    if ({fifo_rd_en, m_valid, busy} !== 3'b000 || m_data !== 32'h0 || m_keep !== 4'h0)
      $display("FAIL mid_reset got ctrl=%b data=%h keep=%b want 000/0/0",
               {fifo_rd_en, m_valid, busy}, m_data, m_keep);
    else n_pass++;
    rst = 1'b0; m_ready = 1'b1;
    base_b = beat_data_q.size();
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    wait_beats(base_b + 1, 30, ok);
    n_total++;
    if (!ok || beat_data_q[base_b] !== 32'h58575655 || beat_keep_q[base_b] !== 4'b1111)
      $display("FAIL post_reset got %h want 58575655", ok ? beat_data_q[base_b] : 32'hx);
    else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_flush_idle();
    int seen_valid = 0, seen_busy = 0, base_b;
    base_b = beat_data_q.size();
    m_ready = 1'b1;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) seen_valid++;
      if (busy) seen_busy++;
      tick();
    end
    n_total++;
    if (seen_valid != 0 || seen_busy != 0 || beat_data_q.size() != base_b)
      $display("FAIL flush_idle got valid=%0d busy=%0d cycles want 0/0", seen_valid, seen_busy);
    else n_pass++;
  endtask

  task automatic test_throughput();
    int base_b, t = 0, first_t = -1;
    m_ready = 1'b1;
    base_b = beat_data_q.size();
    for (int i = 0; i < 40; i++) push(8'($urandom));
    while (beat_data_q.size() < base_b + 10 && t < 200) begin
      tick();
      t++;
      if (first_t < 0 && beat_data_q.size() > base_b) first_t = t;
    end
    n_total++;
    if (first_t < PK + 2) $display("FAIL first_latency got %0d want >= %0d", first_t, PK + 2);
    else n_pass++;
    n_total++;
    if (t > 10 * (PK + 1) + 2)
      $display("FAIL throughput got %0d cycles want <= %0d", t, 10 * (PK + 1) + 2);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      logic [7:0] bytes [$];
      int n, n_full, base_b, n_exp, t;
      bit ok;
      logic [31:0] exp_d;
      logic [3:0]  exp_k;
      n = $urandom_range(5, 40);
      n_full = n / PK;
      n_exp = (n + PK - 1) / PK;
      base_b = beat_data_q.size();
      for (int i = 0; i < n; i++) begin
        bytes.push_back(8'($urandom));
        push(bytes[i]);
      end
      t = 0;
      while ((beat_data_q.size() < base_b + n_full || !fifo_empty) && t < 2000) begin
        m_ready = 1'($urandom_range(0, 1));
        tick();
        t++;
      end
      m_ready = 1'b1;
      repeat (6) tick();
      if (n % PK != 0) begin
        flush = 1'b1; tick(); flush = 1'b0;
      end
      wait_beats(base_b + n_exp, 30, ok);
      repeat (3) tick();
      n_total++;
      if (beat_data_q.size() != base_b + n_exp || busy !== 1'b0)
        $display("FAIL rand_count round %0d got %0d beats busy=%b want %0d beats busy=0",
                 r, beat_data_q.size() - base_b, busy, n_exp);
      else n_pass++;
      for (int g = 0; g < n_exp && base_b + g < beat_data_q.size(); g++) begin
        exp_d = '0;
        exp_k = '0;
        for (int s = 0; s < PK; s++) begin
          if (g * PK + s < n) begin
            exp_d = exp_d | (32'(bytes[g*PK+s]) << (8 * s));
            exp_k[s] = 1'b1;
          end
        end
        n_total++;
        if (beat_data_q[base_b+g] !== exp_d || beat_keep_q[base_b+g] !== exp_k)
          $display("FAIL rand_beat r%0d g%0d got %h/%b want %h/%b", r, g,
                   beat_data_q[base_b+g], beat_keep_q[base_b+g], exp_d, exp_k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_invariants();
    n_total++;
    if (rd_empty_viol != 0) $display("FAIL read_when_empty got %0d want 0", rd_empty_viol);
    else n_pass++;
    n_total++;
    if (stall_viol != 0) $display("FAIL stall_stability got %0d want 0", stall_viol);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_flush_partial();
    test_backpressure();
    test_flush_on_last_read();
    test_reset_midstream();
    test_flush_idle();
    test_throughput();
    test_random(4);
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO read-data width in bits.
REQ-002 SHALL have parameter PACK, default 4, FIFO words packed per output word (power of 2, ≥2).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port fifo_empty, input, 1, upstream sync-FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en, output, 1, read request to upstream FIFO.
REQ-007 SHALL have port fifo_dout, input, DATA_W, FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port flush, input, 1, single-cycle request to emit a partial word.
REQ-009 SHALL have port m_valid, output, 1, packed word available.
REQ-010 SHALL have port m_ready, input, 1, downstream accept.
REQ-011 SHALL have port m_data, output, DATA_W*PACK, packed word.
REQ-012 SHALL have port m_keep, output, PACK, per-slot valid mask.
REQ-013 SHALL have port busy, output, 1, high when byte_cnt≠0, a read is pending, or m_valid=1.

Function
REQ-014 SHALL track rd_pending, a 1-bit register set the cycle after fifo_rd_en=1, so fifo_dout is captured exactly one cycle after each read.
REQ-015 SHALL assert fifo_rd_en only when fifo_empty=0, state=FILL, and byte_cnt+rd_pending < PACK.
REQ-016 SHALL never read from an empty FIFO.
REQ-017 SHALL never drop a returned word.
REQ-018 SHALL write the captured word into assembly slot byte_cnt, with slot 0 at m_data[DATA_W-1:0], then increment byte_cnt (width clog2(PACK)+1).
REQ-019 SHALL transfer the assembly register to the output register when byte_cnt reaches PACK and the output register is empty or accepted that cycle, setting m_keep to all ones and clearing byte_cnt to 0 in the same cycle.
REQ-020 SHALL hold the assembly and block further reads while the output register is full and not accepted.
REQ-021 SHALL complete a transfer only on m_valid=1 and m_ready=1.
REQ-022 SHALL keep m_data and m_keep stable while m_valid=1 and m_ready=0.
REQ-023 SHALL clear m_valid after acceptance unless a new word loads in that cycle.
REQ-024 SHALL implement FSM states FILL and FLUSH.
REQ-025 SHALL move FILL→FLUSH on flush=1 when byte_cnt+rd_pending>0.
REQ-026 SHALL ignore flush when byte_cnt=0, rd_pending=0 and the assembly is empty.
REQ-027 SHALL issue no new reads in FLUSH.
REQ-028 SHALL, in FLUSH, wait for any pending word to land, then load the output register when free with m_keep bit i=1 for slots 0..byte_cnt-1 and unused slots zeroed.
REQ-029 SHALL clear byte_cnt and return to FILL on that load.
REQ-030 SHALL emit a full word with m_keep all ones and return to FILL if the pending word makes byte_cnt=PACK during FLUSH.
REQ-031 SHALL ignore flush asserted while in FLUSH.
REQ-032 SHALL produce first m_valid no earlier than PACK+1 cycles after the first fifo_rd_en.
REQ-033 SHALL sustain PACK words per PACK+1 cycles with m_ready held high.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, drive fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, busy=0, byte_cnt=0, rd_pending=0, state=FILL.
REQ-035 SHALL discard any in-flight FIFO word and any un-accepted output word when rst=1.
REQ-036 SHALL hold fifo_rd_en=0 during reset and keep it at 0 until the first edge after rst deasserts.

Verification
REQ-037 SHALL verify: FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> one beat m_data=0x44332211, m_keep=4'b1111, fifo_rd_en high exactly 4 cycles.
REQ-038 SHALL verify: FIFO holds 0xA1,0xB2,0xC3, then empty, flush pulse -> m_data=0x00C3B2A1, m_keep=4'b0111, state back to FILL, busy=0 after acceptance.
REQ-039 SHALL verify: 8 bytes 0x01..0x08, m_ready=0 for 10 cycles then 1 -> beat 0x04030201 held stable while stalled, then 0x08070605, no byte lost or duplicated, rd_en never asserted while fifo_empty=1.
REQ-040 SHALL verify: flush on the cycle the 4th read is issued -> single beat with m_keep=4'b1111, no extra partial beat.
REQ-041 SHALL verify: rst asserted with byte_cnt=2 and m_valid=1 -> next cycle all outputs 0, subsequent 4 bytes 0x55..0x58 yield 0x58575655.
REQ-042 SHALL verify: flush with byte_cnt=0 and empty FIFO -> no m_valid, busy stays 0.
